i2c_target: RTL

- I2C target (slave) endpoint: the responder side of the bus driven by the team's I2C controller.
- Lets an external controller, or a second chip, write bytes into the core and read bytes out of it.
- Sits in chip_core behind one bidir pad pair (SCL input only, SDA open-drain). Pad pull-ups are enabled by the core; no clock stretching.
- Byte-stream interface to the core: rx_valid/rx_ready for writes, tx_req/tx_data for reads.

---
 rtl/i2c_target.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address match, byte write/read streams to the core.
// SCL is input only, SDA is driven open-drain through sda_oe; no clock stretching.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match;
  state_t                 r_state;
  logic [7:0]             r_shift;
  logic [3:0]             r_bitcnt;
  logic                   r_rw, r_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl        = r_scl_sync[SYNC_STAGES-1];
  assign w_sda        = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise   = w_scl & ~r_scl_d;
  assign w_scl_fall   = ~w_scl & r_scl_d;
  // SDA transitions only count as START/STOP while SCL is stably high
  assign w_start      = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop       = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_addr_match = (r_shift[7:1] == ADDR) && (ADDR != 7'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_bitcnt  <= 4'd0;
      r_rw      <= 1'b0;
      r_ack     <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bitcnt  <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        start_det <= 1'b1;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_bitcnt <= 4'd0;
              if (w_addr_match) begin
                r_state <= S_ADDR_ACK;
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
                r_rw    <= r_shift[0];
                tx_req  <= r_shift[0];
              end else begin
                r_state <= S_IGNORE;
                sda_oe  <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_state  <= S_RD_DATA;
                r_shift  <= tx_data;
                sda_oe   <= ~tx_data[7];
                r_bitcnt <= 4'd1;
              end else begin
                r_state  <= S_WR_DATA;
                sda_oe   <= 1'b0;
                r_bitcnt <= 4'd0;
              end
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_ack <= rx_ready;
                if (rx_ready) begin
                  rx_data  <= {r_shift[6:0], w_sda};
                  rx_valid <= 1'b1;
                end
              end
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_state  <= S_WR_ACK;
              sda_oe   <= r_ack;
              r_bitcnt <= 4'd0;
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              sda_oe <= 1'b0;
              if (r_ack) begin
                r_state <= S_WR_DATA;
              end else begin
                r_state <= S_IGNORE;
                busy    <= 1'b0;
              end
            end
          end
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_state <= S_RD_ACK;
                sda_oe  <= 1'b0;
              end else begin
                sda_oe   <= ~r_shift[6];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_state <= S_IGNORE;
                busy    <= 1'b0;
              end else begin
                tx_req <= 1'b1;
              end
            end else if (w_scl_fall) begin
              r_state  <= S_RD_DATA;
              r_shift  <= tx_data;
              sda_oe   <= ~tx_data[7];
              r_bitcnt <= 4'd1;
            end
          end
          S_IGNORE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
